// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the sprite draw scheduler.
//   sprite_desc_t : packed draw descriptor {rom_addr, x, y, w, h}
//   sched_state_t : scheduler FSM states
//   ROM_ADDR_W / COORD_W : field widths
package sprite_pkg;

  localparam int ROM_ADDR_W = 12;
  localparam int COORD_W    = 10;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [COORD_W-1:0]    x;
    logic [COORD_W-1:0]    y;
    logic [COORD_W-1:0]    w;
    logic [COORD_W-1:0]    h;
  } sprite_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req     : request vector
//   i_pointer : index where the search starts (highest priority)
//   o_winner  : one-hot winner (zero when nothing requested)
//   o_valid   : at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_pointer,
  output logic [N-1:0]  o_winner,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;

  // Walk N slots starting at the pointer; first set bit wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(i_pointer) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: round-robin scheduler of sprite draw jobs onto a
// single sprite ROM reader.
//   clk, reset (async, active high)
//   req[NUM_REQ], req_desc[NUM_REQ] : level requests + descriptors
//   gnt[NUM_REQ]    : one-cycle one-hot accept pulse
//   begin_drawing   : one-cycle start pulse to reader, draw_desc held
//   done_drawing    : completion pulse from reader
//   busy            : FSM not in IDLE
//   draws_done      : completed-job counter (wraps)
//   timeout_err / err_clr : sticky watchdog flag and its clear
// Optional: define SPRITE_SCHED_TIMEOUT_EN to enable the WAIT watchdog.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic         [NUM_REQ-1:0] req,
  input  sprite_desc_t [NUM_REQ-1:0] req_desc,
  output logic         [NUM_REQ-1:0] gnt,
  output logic                       begin_drawing,
  output sprite_desc_t               draw_desc,
  input  logic                       done_drawing,
  output logic                       busy,
  output logic [7:0]                 draws_done,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int PW = $clog2(NUM_REQ);

  sched_state_t        r_state, w_state_nxt;
  logic [PW-1:0]       r_ptr, w_win_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_win, r_gnt;
  logic                w_valid, w_zero, w_grant, w_issue, w_done, w_tmo;
  sprite_desc_t        w_sel_desc, r_desc;
  logic                r_begin;
  logic [7:0]          r_draws;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .i_req     (req),
    .i_pointer (r_ptr),
    .o_winner  (w_win),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_win_idx  = '0;
    w_sel_desc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = PW'(i);
        w_sel_desc = req_desc[i];
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == PW'(NUM_REQ-1)) ? '0 : w_win_idx + PW'(1);
  assign w_zero    = (w_sel_desc.w == '0) || (w_sel_desc.h == '0);

`ifdef SPRITE_SCHED_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_terr;
  logic        w_wd_hit;
  assign w_wd_hit = (r_wd == TIMEOUT_CYCLES - 16'd1);
`else
  logic w_wd_hit;
  logic w_unused;
  assign w_wd_hit = 1'b0;
  assign w_unused = err_clr ^ (|TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: if (w_valid) begin
        w_grant = 1'b1;
        // Zero-size jobs are acknowledged but never reach the reader.
        w_state_nxt = w_zero ? IDLE : ISSUE;
      end
      ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (done_drawing) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end else if (w_wd_hit) begin
        w_tmo       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_begin <= 1'b0;
      r_desc  <= '0;
      r_draws <= '0;
    end else begin
      r_gnt   <= w_grant ? w_win : '0;
      r_begin <= w_issue;
      if (w_grant) begin
        r_desc <= w_sel_desc;
        r_ptr  <= w_ptr_nxt;
      end
      if (w_done) r_draws <= r_draws + 8'd1;
    end
  end

`ifdef SPRITE_SCHED_TIMEOUT_EN
  // Counter restarts when WAIT is entered (ISSUE cycle), counts WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd   <= '0;
      r_terr <= 1'b0;
    end else begin
      if (w_issue)               r_wd <= '0;
      else if (r_state == WAIT)  r_wd <= r_wd + 16'd1;
      // Setting beats a simultaneous clear.
      if (w_tmo)        r_terr <= 1'b1;
      else if (err_clr) r_terr <= 1'b0;
    end
  end
  assign timeout_err = r_terr;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt           = r_gnt;
  assign begin_drawing = r_begin;
  assign draw_desc     = r_desc;
  assign busy          = (r_state != IDLE);
  assign draws_done    = r_draws;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=8).
module tb_sprite_draw_scheduler;
  import sprite_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0]         req = '0;
  sprite_desc_t [N-1:0] req_desc;
  logic [N-1:0]         gnt;
  logic                 begin_drawing;
  sprite_desc_t         draw_desc;
  logic                 done_drawing = 1'b0;
  logic                 busy;
  logic [7:0]           draws_done;
  logic                 timeout_err;
  logic                 err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_draw_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_desc(req_desc), .gnt(gnt),
    .begin_drawing(begin_drawing), .draw_desc(draw_desc),
    .done_drawing(done_drawing), .busy(busy), .draws_done(draws_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; sampling happens 1 time unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; #3; reset = 1'b0;
  endtask

  initial begin
    sprite_desc_t d2;
    d2 = '{rom_addr:12'h100, x:10'd10, y:10'd20, w:10'd16, h:10'd16};
    for (int i = 0; i < N; i++)
      req_desc[i] = '{rom_addr:12'(i + 1), x:10'd1, y:10'd2, w:10'd4, h:10'd4};
    req_desc[2] = d2;

    tick(); do_reset(); tick();
    chk("rst_gnt",   64'(gnt), 64'h0);
    chk("rst_begin", 64'(begin_drawing), 64'h0);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_cnt",   64'(draws_done), 64'h0);
    chk("rst_terr",  64'(timeout_err), 64'h0);
    chk("rst_desc",  64'(draw_desc), 64'h0);

    // Single requester 2, full handshake.
    req = 4'b0100; tick();
    chk("s_gnt",  64'(gnt), 64'h4);
    chk("s_busy", 64'(busy), 64'h1);
    chk("s_desc", 64'(draw_desc), 64'(d2));
    req = '0; tick();
    chk("s_begin", 64'(begin_drawing), 64'h1);
    chk("s_gnt0",  64'(gnt), 64'h0);
    tick();
    chk("s_begin1", 64'(begin_drawing), 64'h0);
    chk("s_descst", 64'(draw_desc), 64'(d2));
    tick(); tick(); tick();
    chk("s_wait", 64'(busy), 64'h1);
    done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    chk("s_idle", 64'(busy), 64'h0);
    chk("s_cnt",  64'(draws_done), 64'h1);

    // All four requesting: order 0,1,2,3,0 after reset.
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("rr_gnt%0d", j), 64'(gnt), 64'(4'b0001 << (j % 4)));
      tick();
      chk($sformatf("rr_beg%0d", j), 64'(begin_drawing), 64'h1);
      done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    end
    req = '0;
    chk("rr_cnt", 64'(draws_done), 64'h5);
    // done in IDLE is ignored.
    done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    chk("idle_done", 64'(draws_done), 64'h5);

    // Zero-width job on requester 1 (pointer is now 1).
    req_desc[1].w = 10'd0;
    req = 4'b0010; tick();
    chk("z_gnt",  64'(gnt), 64'h2);
    req = '0; tick();
    chk("z_begin", 64'(begin_drawing), 64'h0);
    chk("z_busy",  64'(busy), 64'h0);
    chk("z_cnt",   64'(draws_done), 64'h5);

    // Reset in WAIT abandons the job.
    req = 4'b0001; tick();
    chk("r_gnt", 64'(gnt), 64'h1);
    req = '0; tick(); tick();
    chk("r_wait", 64'(busy), 64'h1);
    #2 reset = 1'b1; #1;
    chk("r_busy", 64'(busy), 64'h0);
    chk("r_cnt",  64'(draws_done), 64'h0);
    chk("r_desc", 64'(draw_desc), 64'h0);
    chk("r_gntz", 64'(gnt | N'(begin_drawing)), 64'h0);
    reset = 1'b0;
    req = 4'b1000; tick();
    chk("r_gnt3", 64'(gnt), 64'h8);
    // Pending requests during the job wait for IDLE; pointer wrapped to 0.
    req = 4'b0011; tick();
    chk("p_gnt0", 64'(gnt), 64'h0);
    done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    chk("p_idle", 64'(gnt), 64'h0);
    tick();
    chk("p_gnt",  64'(gnt), 64'h1);
    req = '0; tick();
    done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    tick();

    // Watchdog.
    do_reset();
    req = 4'b0001; tick(); req = '0; tick();
`ifdef SPRITE_SCHED_TIMEOUT_EN
    for (int k = 0; k < 7; k++) tick();
    chk("t_pre_busy", 64'(busy), 64'h1);
    chk("t_pre_err",  64'(timeout_err), 64'h0);
    tick();
    chk("t_busy", 64'(busy), 64'h0);
    chk("t_err",  64'(timeout_err), 64'h1);
    chk("t_cnt",  64'(draws_done), 64'h0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t_clr", 64'(timeout_err), 64'h0);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("t_busy", 64'(busy), 64'h1);
    chk("t_err",  64'(timeout_err), 64'h0);
    done_drawing = 1'b1; tick(); done_drawing = 1'b0;
    chk("t_done", 64'(busy), 64'h0);
`endif

    // 256 jobs wrap the completion counter.
    do_reset();
    req_desc[1].w = 10'd4;
    req = 4'b0001;
    for (int j = 0; j < 256; j++) begin
      tick(); tick();
      done_drawing = 1'b1; tick(); done_drawing = 1'b0;
      if (j == 254) chk("w_255", 64'(draws_done), 64'hff);
    end
    req = '0;
    chk("w_wrap", 64'(draws_done), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of sprite requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester draw request, level, held until granted.
REQ-006 SHALL have port req_desc  input  NUM_REQ x sprite_desc_t  per-requester descriptor: rom_addr[11:0], x[9:0], y[9:0], w[9:0], h[9:0].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot, one-cycle pulse: descriptor accepted.
REQ-008 SHALL have port begin_drawing  output  1  one-cycle start pulse to sprite ROM reader.
REQ-009 SHALL have port draw_desc  output  sprite_desc_t  latched descriptor driven to reader, stable from begin_drawing until job ends.
REQ-010 SHALL have port done_drawing  input  1  completion pulse from reader.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port draws_done  output  8  count of completed jobs, wraps 255->0.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog flag.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of timeout_err.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-016 IDLE with any req bit high at edge N: SHALL select winner round-robin, latch its descriptor into draw_desc, pulse gnt[winner] in cycle N+1, enter ISSUE.
REQ-017 Round-robin: search starts at pointer P (reset 0); after grant to i, P = (i+1) mod NUM_REQ.
REQ-018 ISSUE SHALL assert begin_drawing for exactly one cycle (N+2), then enter WAIT.
REQ-019 Zero-size descriptor (w==0 or h==0): gnt still pulses; SHALL skip ISSUE/WAIT, return to IDLE, no begin_drawing, draws_done unchanged.
REQ-020 WAIT on done_drawing SHALL return to IDLE next cycle and increment draws_done.
REQ-021 done_drawing in IDLE or ISSUE SHALL be ignored.
REQ-022 A request arriving during ISSUE/WAIT SHALL stay pending; earliest grant is the cycle after return to IDLE.
REQ-023 req bits deasserting before grant SHALL be dropped with no side effect.
REQ-024 err_clr and timeout set in the same cycle: set SHALL win.

Reset
REQ-025 Reset SHALL force IDLE, P=0, gnt=0, begin_drawing=0, draw_desc=0, busy=0, draws_done=0, timeout_err=0, watchdog counter=0.
REQ-026 Reset during ISSUE or WAIT SHALL abandon the job without begin_drawing or a draws_done increment.

Configuration
REQ-027 With SPRITE_SCHED_TIMEOUT_EN defined: 16-bit counter clears on WAIT entry, increments per WAIT cycle; reaching TIMEOUT_CYCLES without done_drawing SHALL set timeout_err and return to IDLE, draws_done unchanged.
REQ-028 Without SPRITE_SCHED_TIMEOUT_EN: no counter; WAIT SHALL wait indefinitely; timeout_err tied 0; err_clr ignored.

Structure
REQ-029 sprite_pkg SHALL hold sprite_desc_t (packed struct), the FSM state enum, and width constants ROM_ADDR_W=12, COORD_W=10.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot winner, valid).

Verification
REQ-031 Single req[2] with desc {0x100,10,20,16,16}: gnt[2] at N+1, begin_drawing at N+2, draw_desc matches; done_drawing 5 cycles later -> IDLE, draws_done=1.
REQ-032 req=4'b1111 held, immediate done each job: grant order 0,1,2,3,0; no requester granted twice before the others.
REQ-033 req[1] with w=0: gnt[1] pulses, no begin_drawing, busy low again by N+2, draws_done unchanged.
REQ-034 Reset asserted in WAIT: all outputs zero at once; subsequent req[3] granted first (P=0 search finds 3).
REQ-035 Macro defined, TIMEOUT_CYCLES=8, no done_drawing: timeout_err high after 8 WAIT cycles, IDLE; err_clr pulse clears it.
REQ-036 256 completed jobs: draws_done wraps to 0.
